// File: rtl/pipe_lsu.sv
// pipe_lsu: MEM-stage load/store unit for the 5-stage core.
// Handles byte/half/word accesses with byte enables and lane replication, sign/zero extension of loads,
// a variable-latency memory handshake with an optional timeout, and flush of the pending response.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word requests complete with resp_err and never reach memory.
//   undefined -> low address bits are forced to natural alignment and the access proceeds normally.
module pipe_lsu #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    // A zero-width counter is illegal, so a disabled timeout still keeps one (unused) bit.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // The timeout fires on the BUS cycle whose count is TIMEOUT_CYC-1, so mem_req is high TIMEOUT_CYC cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         lo_q, lo_d;
    logic               uns_q, uns_d;
    logic [4:0]         rd_q, rd_d;

    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [4:0]         resp_rd_q, resp_rd_d;
    logic               resp_err_q, resp_err_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    // Request decode
    logic               is_half;
    logic               is_word;
    logic               trap;
    logic [1:0]         eff_lo;
    logic [3:0]         req_be;
    logic [31:0]        req_wlanes;

    // Load path
    logic [7:0]         rd_lane [4];
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;
    logic               timeout_hit;

    assign is_half = (req_size_i == 2'b01);
    assign is_word = req_size_i[1];  // 10 and 11 are both word accesses

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (is_half && req_addr_i[0]) || (is_word && (req_addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Effective low address bits, byte enables and replicated store data for the incoming request
    always_comb begin
        eff_lo     = req_addr_i[1:0];
        req_be     = 4'b0001 << req_addr_i[1:0];
        req_wlanes = {4{req_wdata_i[7:0]}};
        if (is_word) begin
            eff_lo     = 2'b00;
            req_be     = 4'hF;
            req_wlanes = req_wdata_i;
        end else if (is_half) begin
            eff_lo     = {req_addr_i[1], 1'b0};
            req_be     = 4'b0011 << {req_addr_i[1], 1'b0};
            req_wlanes = {2{req_wdata_i[15:0]}};
        end
    end

    // Split the read bus into byte lanes for the load selector
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_lane[gi] = mem_rdata_i[8*gi +: 8];
    end

    // Select the addressed lane of the returning word and extend it to 32 bits
    always_comb begin
        ld_byte = rd_lane[lo_q];
        ld_half = lo_q[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    // Next-state and registered-output logic for the IDLE/BUS/DONE controller
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_d      = flush_q;
        we_d         = we_q;
        size_d       = size_q;
        lo_d         = lo_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                flush_d = 1'b0;
                // A flush in the same cycle squashes the request before it is taken
                if (req_valid_i && !flush_i) begin
                    we_d   = req_we_i;
                    size_d = req_size_i;
                    lo_d   = eff_lo;
                    uns_d  = req_unsigned_i;
                    rd_d   = req_rd_i;
                    if (trap) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'h0;
                        resp_rd_d    = req_we_i ? 5'd0 : req_rd_i;
                    end else begin
                        state_d     = S_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wlanes;
                    end
                end
            end

            S_BUS: begin
                // The bus access itself is never cancelled; only the response is squashed
                if (flush_i) begin
                    flush_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d      = S_DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = !(flush_q || flush_i);
                    resp_err_d   = 1'b0;
                    resp_data_d  = we_q ? 32'h0 : ld_ext;
                    resp_rd_d    = we_q ? 5'd0 : rd_q;
                end else begin
                    if (TIMEOUT_CYC != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (timeout_hit) begin
                        state_d      = S_DONE;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        resp_valid_d = !(flush_q || flush_i);
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'h0;
                        resp_rd_d    = we_q ? 5'd0 : rd_q;
                    end
                end
            end

            S_DONE: begin
                state_d      = S_IDLE;
                flush_d      = 1'b0;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_data_d  = 32'h0;
                resp_rd_d    = 5'd0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            lo_q         <= 2'b00;
            uns_q        <= 1'b0;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            we_q         <= we_d;
            size_q       <= size_d;
            lo_q         <= lo_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    // A flush arriving during DONE must still kill the pulse that is already registered
    assign resp_valid_o = resp_valid_q && !flush_i;
    assign resp_data_o  = resp_data_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_err_o   = resp_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_pipe_lsu.sv
// tb_pipe_lsu: directed vectors for pipe_lsu with hand-computed expectations (TIMEOUT_CYC = 4).
module tb_pipe_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    pipe_lsu #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_rd_i       (req_rd),
        .flush_i        (flush),
        .busy_o         (busy),
        .resp_valid_o   (resp_valid),
        .resp_data_o    (resp_data),
        .resp_rd_o      (resp_rd),
        .resp_err_o     (resp_err),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; on return the DUT is in the cycle after acceptance
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Acknowledge in the current BUS cycle with the given read data
    task automatic ack_now(input logic [31:0] rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int hi_cnt;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        check_val("reset busy",       32'(busy), 32'd0);
        check_val("reset mem_req",    32'(mem_req), 32'd0);
        check_val("reset resp_valid", 32'(resp_valid), 32'd0);
        check_val("reset resp_data",  resp_data, 32'h0);
        check_val("reset mem_be",     32'(mem_be), 32'h0);
        rst = 1'b1;
        tick();

        // 1: lb signed at 0x103
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd5);
        check_val("lb mem_req",  32'(mem_req), 32'd1);
        check_val("lb mem_addr", mem_addr, 32'h0000_0100);
        check_val("lb mem_be",   32'(mem_be), 32'h8);
        check_val("lb mem_we",   32'(mem_we), 32'd0);
        check_val("lb busy",     32'(busy), 32'd1);
        ack_now(32'h80FF_1234);
        check_val("lb resp_valid", 32'(resp_valid), 32'd1);
        check_val("lb resp_data",  resp_data, 32'hFFFF_FF80);
        check_val("lb resp_rd",    32'(resp_rd), 32'd5);
        check_val("lb resp_err",   32'(resp_err), 32'd0);
        check_val("lb mem_req off", 32'(mem_req), 32'd0);
        tick();
        check_val("lb idle busy",  32'(busy), 32'd0);
        check_val("lb idle valid", 32'(resp_valid), 32'd0);

        // 2: lhu at 0x202
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 5'd9);
        check_val("lhu mem_be", 32'(mem_be), 32'hC);
        ack_now(32'hBEEF_0000);
        check_val("lhu resp_data", resp_data, 32'h0000_BEEF);
        check_val("lhu resp_rd",   32'(resp_rd), 32'd9);
        tick();

        // lh signed at 0x200
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 5'd4);
        check_val("lh mem_be", 32'(mem_be), 32'h3);
        ack_now(32'h0000_8001);
        check_val("lh resp_data", resp_data, 32'hFFFF_8001);
        tick();

        // 3: sh at 0x202, ack in the third BUS cycle
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd12);
        check_val("sh mem_be",    32'(mem_be), 32'hC);
        check_val("sh mem_wdata", mem_wdata, 32'hABCD_ABCD);
        check_val("sh mem_we",    32'(mem_we), 32'd1);
        tick();
        check_val("sh wait valid", 32'(resp_valid), 32'd0);
        check_val("sh wait req",   32'(mem_req), 32'd1);
        tick();
        ack_now(32'hFFFF_FFFF);
        check_val("sh resp_valid", 32'(resp_valid), 32'd1);
        check_val("sh resp_data",  resp_data, 32'h0);
        check_val("sh resp_rd",    32'(resp_rd), 32'd0);
        check_val("sh resp_err",   32'(resp_err), 32'd0);
        check_val("sh busy done",  32'(busy), 32'd1);
        tick();
        check_val("sh busy after", 32'(busy), 32'd0);
        check_val("sh valid after", 32'(resp_valid), 32'd0);

        // sb at 0x301
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_005A, 5'd1);
        check_val("sb mem_be",    32'(mem_be), 32'h2);
        check_val("sb mem_wdata", mem_wdata, 32'h5A5A_5A5A);
        ack_now(32'h0);
        tick();

        // lw aligned at 0x400, size code 11 behaves as word
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0, 5'd2);
        check_val("lw11 mem_be", 32'(mem_be), 32'hF);
        ack_now(32'h1234_5678);
        check_val("lw11 resp_data", resp_data, 32'h1234_5678);
        tick();

        // 4: lw misaligned at 0x101
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        check_val("mis mem_req",    32'(mem_req), 32'd0);
        check_val("mis resp_valid", 32'(resp_valid), 32'd1);
        check_val("mis resp_err",   32'(resp_err), 32'd1);
        check_val("mis resp_data",  resp_data, 32'h0);
        tick();
        check_val("mis busy after", 32'(busy), 32'd0);
`else
        check_val("mis mem_req",  32'(mem_req), 32'd1);
        check_val("mis mem_addr", mem_addr, 32'h0000_0100);
        check_val("mis mem_be",   32'(mem_be), 32'hF);
        ack_now(32'hCAFE_F00D);
        check_val("mis resp_data", resp_data, 32'hCAFE_F00D);
        check_val("mis resp_err",  32'(resp_err), 32'd0);
        tick();
`endif

        // 5: timeout with no ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd6);
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (!mem_req) break;
            hi_cnt++;
            tick();
        end
        check_val("to req cycles", 32'(hi_cnt), 32'd4);
        check_val("to resp_valid", 32'(resp_valid), 32'd1);
        check_val("to resp_err",   32'(resp_err), 32'd1);
        check_val("to resp_data",  resp_data, 32'h0);
        tick();

        // ack on the same edge as the timeout wins
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 5'd8);
        tick(); tick(); tick();
        ack_now(32'h1111_2222);
        check_val("to-ack err",  32'(resp_err), 32'd0);
        check_val("to-ack data", resp_data, 32'h1111_2222);
        tick();

        // 6: flush during BUS
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fl still req", 32'(mem_req), 32'd1);
        tick();
        ack_now(32'hDEAD_BEEF);
        check_val("fl resp_valid", 32'(resp_valid), 32'd0);
        check_val("fl busy",       32'(busy), 32'd1);
        tick();
        check_val("fl busy after", 32'(busy), 32'd0);

        // flush coincident with a request in IDLE
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0800; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check_val("fl-idle busy",    32'(busy), 32'd0);
        check_val("fl-idle mem_req", 32'(mem_req), 32'd0);

        // flush during DONE
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0900, 32'h0, 5'd10);
        ack_now(32'h0000_0001);
        flush = 1'b1;
        #1;
        check_val("fl-done valid", 32'(resp_valid), 32'd0);
        tick();
        flush = 1'b0;

        // mem_ack outside BUS is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("stray ack busy",  32'(busy), 32'd0);
        check_val("stray ack valid", 32'(resp_valid), 32'd0);

        // reset while in BUS
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0A00, 32'h0, 5'd11);
        check_val("rst-bus req before", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("rst-bus mem_req", 32'(mem_req), 32'd0);
        check_val("rst-bus busy",    32'(busy), 32'd0);
        check_val("rst-bus valid",   32'(resp_valid), 32'd0);
        tick();
        check_val("rst-bus no resp", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
